// File: rtl/pgseq_pkg.sv
// Shared types and constants for the bubble-memory page access sequencer.
package pgseq_pkg;

  localparam int unsigned PG_W_DEF    = 12;
  localparam int unsigned ROT_STEPS   = 20;
  localparam int unsigned RESULT_STEP = 12;
  localparam int unsigned STEP_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN
  } state_e;

endpackage

// File: rtl/mdl_pgserial_cmp.sv
// Bit-serial invalid-page accumulator, LSB first.
// INVALPG_GTE_EN selects page >= limit (borrow chain); otherwise page == 0.
module mdl_pgserial_cmp (
  input  logic i_MCLK,
  input  logic i_RST,
  input  logic i_CLR,
  input  logic i_SHIFT_EN,
  input  logic i_PG_BIT,
  input  logic i_LIM_BIT,
  output logic o_INVALID_c
);

  logic acc_q;
  logic acc_d;

`ifndef INVALPG_GTE_EN
  logic unused_lim_bit;
  assign unused_lim_bit = i_LIM_BIT;
`endif

  // acc is the running borrow (GTE) or the OR of page bits seen so far
  always_comb begin
    acc_d = acc_q;
    if (i_CLR) begin
      acc_d = 1'b0;
    end else if (i_SHIFT_EN) begin
`ifdef INVALPG_GTE_EN
      acc_d = (~i_PG_BIT & i_LIM_BIT) | (~(i_PG_BIT ^ i_LIM_BIT) & acc_q);
`else
      acc_d = acc_q | i_PG_BIT;
`endif
    end
  end

  // Reflects the bit being shifted this cycle so the result can be latched on the same edge
  assign o_INVALID_c = ~acc_d;

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) acc_q <= 1'b0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/mdl_pgaccess_seq.sv
// Page access sequencer: accepts a request, steps a 20-phase active-low ring on the
// 2 MHz enable and serially checks the page. Optional macro: INVALPG_GTE_EN.
module mdl_pgaccess_seq
  import pgseq_pkg::*;
#(
  parameter int unsigned PG_W = PG_W_DEF
) (
  input  logic                 i_MCLK,
  input  logic                 i_RST,
  input  logic                 i_CLK2M_PCEN_n,
  input  logic                 i_REQ,
  input  logic [PG_W-1:0]      i_PAGE,
  input  logic [PG_W-1:0]      i_INVALPG,
  input  logic                 i_UMODE_n,
  output logic                 o_ACK,
  output logic                 o_BUSY,
  output logic [ROT_STEPS-1:0] o_ROT20_n,
  output logic                 o_PGREG_SR_LSB,
  output logic                 o_ACC_INVAL_n,
  output logic                 o_DONE
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                load_tick_q, load_tick_d;
  logic                ack_d, busy_d, done_d, inval_n_d;
  logic [ROT_STEPS-1:0] ring_d;
  logic                tick, accept, shift_en, invalid_c, lim_bit;
  logic [PG_W-1:0]     page_sr;

  assign tick           = ~i_CLK2M_PCEN_n;
  assign o_PGREG_SR_LSB = page_sr[0];

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    load_tick_d = load_tick_q;
    ack_d       = 1'b0;
    done_d      = 1'b0;
    busy_d      = o_BUSY;
    ring_d      = o_ROT20_n;
    inval_n_d   = o_ACC_INVAL_n;
    accept      = 1'b0;
    shift_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_REQ) begin
          state_d     = LOAD;
          accept      = 1'b1;
          ack_d       = 1'b1;
          busy_d      = 1'b1;
          load_tick_d = 1'b0;
          inval_n_d   = 1'b1;
        end
      end
      LOAD: begin
        if (tick) begin
          if (load_tick_q) begin
            state_d     = SCAN;
            step_d      = '0;
            load_tick_d = 1'b0;
            ring_d      = ~ROT_STEPS'(1);
          end else begin
            load_tick_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (tick) begin
          shift_en = (step_q < STEP_W'(PG_W));
          if (step_q == STEP_W'(ROT_STEPS - 1)) begin
            state_d = IDLE;
            step_d  = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ring_d  = '1;
          end else begin
            step_d = step_q + STEP_W'(1);
            ring_d = {o_ROT20_n[ROT_STEPS-2:0], o_ROT20_n[ROT_STEPS-1]};
            if (step_q == STEP_W'(RESULT_STEP - 1)) begin
              inval_n_d = ~(invalid_c & ~i_UMODE_n);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q       <= IDLE;
      step_q        <= '0;
      load_tick_q   <= 1'b0;
      o_ACK         <= 1'b0;
      o_BUSY        <= 1'b0;
      o_DONE        <= 1'b0;
      o_ROT20_n     <= '1;
      o_ACC_INVAL_n <= 1'b1;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      load_tick_q   <= load_tick_d;
      o_ACK         <= ack_d;
      o_BUSY        <= busy_d;
      o_DONE        <= done_d;
      o_ROT20_n     <= ring_d;
      o_ACC_INVAL_n <= inval_n_d;
    end
  end

  // Page shift register: loaded on acceptance, shifted right LSB first
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST)         page_sr <= '0;
    else if (accept)   page_sr <= i_PAGE;
    else if (shift_en) page_sr <= page_sr >> 1;
  end

`ifdef INVALPG_GTE_EN
  logic [PG_W-1:0] lim_sr;

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST)         lim_sr <= '0;
    else if (accept)   lim_sr <= i_INVALPG;
    else if (shift_en) lim_sr <= lim_sr >> 1;
  end

  assign lim_bit = lim_sr[0];
`else
  logic unused_invalpg;
  assign unused_invalpg = ^i_INVALPG;
  assign lim_bit        = 1'b0;
`endif

  mdl_pgserial_cmp u_cmp (
    .i_MCLK      (i_MCLK),
    .i_RST       (i_RST),
    .i_CLR       (accept),
    .i_SHIFT_EN  (shift_en),
    .i_PG_BIT    (page_sr[0]),
    .i_LIM_BIT   (lim_bit),
    .o_INVALID_c (invalid_c)
  );

endmodule

// File: tb/tb_mdl_pgaccess_seq.sv
// Self-checking bench for mdl_pgaccess_seq with a random 2 MHz enable and a tick-count reference model.
module tb_mdl_pgaccess_seq;

  localparam int unsigned PW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pcen_n = 1'b1;
  logic          req = 1'b0;
  logic          umode_n = 1'b1;
  logic [PW-1:0] page = '0;
  logic [PW-1:0] lim = '0;
  logic          freeze = 1'b0;

  logic          ack, busy, lsb, inval_n, done;
  logic [19:0]   rot;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdl_pgaccess_seq #(.PG_W(PW)) dut (
    .i_MCLK         (clk),
    .i_RST          (rst),
    .i_CLK2M_PCEN_n (pcen_n),
    .i_REQ          (req),
    .i_PAGE         (page),
    .i_INVALPG      (lim),
    .i_UMODE_n      (umode_n),
    .o_ACK          (ack),
    .o_BUSY         (busy),
    .o_ROT20_n      (rot),
    .o_PGREG_SR_LSB (lsb),
    .o_ACC_INVAL_n  (inval_n),
    .o_DONE         (done)
  );

  // Random enable: roughly one tick in three MCLKs, forced off while frozen
  initial begin
    forever begin
      @(negedge clk);
      pcen_n = freeze ? 1'b1 : (($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1);
    end
  end

  // mode: 0 plain, 1 REQ pulse mid-scan, 2 REQ held through DONE, 3 freeze at step 5, 4 reset at step 7
  task automatic run_access(input logic [PW-1:0] p, input logic [PW-1:0] l,
                            input logic um, input int mode);
    logic        inv, want_inval_n, tk, exp_lsb, exp_inv_n, pulsed;
    logic [19:0] exp_rot;
    logic [24:0] obs, exp_v;
    int          n, cyc, frz_left, s;
`ifdef INVALPG_GTE_EN
    inv = (p >= l);
`else
    inv = (p == '0);
`endif
    want_inval_n = ~(inv & ~um);
    @(negedge clk);
    page = p; lim = l; umode_n = um; req = 1'b1;
    @(posedge clk); #1;
    obs   = {ack, busy, done, inval_n, lsb, rot};
    exp_v = {1'b1, 1'b1, 1'b0, 1'b1, p[0], 20'hFFFFF};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL accept p=%h: got %h want %h", p, obs, exp_v);
    end
    if (mode != 2) req = 1'b0;
    n = 0; cyc = 0; frz_left = 0; pulsed = 1'b0;
    while (n < 22 && cyc < 4000) begin
      @(posedge clk);
      tk = (pcen_n == 1'b0);
      #1;
      cyc++;
      if (tk) n++;
      s = n - 2;
      exp_rot = (n >= 2 && n <= 21) ? ~(20'(1) << s) : 20'hFFFFF;
      if (n < 2)       exp_lsb = p[0];
      else if (s < PW) exp_lsb = p[s];
      else             exp_lsb = 1'b0;
      exp_inv_n = (n >= 14) ? want_inval_n : 1'b1;
      exp_v = {1'b0, (n < 22), (n == 22), exp_inv_n, exp_lsb, exp_rot};
      obs   = {ack, busy, done, inval_n, lsb, rot};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL seq p=%h l=%h um=%b tick=%0d: got %h want %h", p, l, um, n, obs, exp_v);
      end
      if (mode == 1) begin
        if (n == 6 && !pulsed) begin req = 1'b1; pulsed = 1'b1; end
        else req = 1'b0;
      end
      if (mode == 3) begin
        if (n == 7 && !pulsed) begin
          freeze = 1'b1; frz_left = 50; pulsed = 1'b1;
        end else if (frz_left > 0) begin
          frz_left--;
          if (frz_left == 0) freeze = 1'b0;
        end
      end
      if (mode == 4 && n == 9) begin
        #2 rst = 1'b1;
        #1;
        obs   = {ack, busy, done, inval_n, lsb, rot};
        exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'hFFFFF};
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL reset_mid: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    total++;
    if (n != 22) begin
      bad++;
      $display("FAIL timeout: got ticks=%0d want 22", n);
    end
    @(posedge clk); #1;
    if (mode == 2) begin
      total++;
      if ({ack, busy} !== 2'b11) begin
        bad++;
        $display("FAIL reaccept: got ack/busy=%b want 11", {ack, busy});
      end
      req = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      total++;
      if ({ack, busy, done, rot} !== {3'b000, 20'hFFFFF}) begin
        bad++;
        $display("FAIL idle_after_done: got %b_%h want 000_fffff", {ack, busy, done}, rot);
      end
    end
  endtask

  task automatic test_reset();
    logic [24:0] obs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {ack, busy, done, inval_n, lsb, rot};
    total++;
    if (obs !== {5'b00010, 20'hFFFFF}) begin
      bad++;
      $display("FAIL reset_hold: got %h want %h", obs, {5'b00010, 20'hFFFFF});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {ack, busy, done, inval_n, lsb, rot};
    total++;
    if (obs !== {5'b00010, 20'hFFFFF}) begin
      bad++;
      $display("FAIL reset_idle: got %h want %h", obs, {5'b00010, 20'hFFFFF});
    end
  endtask

  task automatic test_directed();
    run_access(12'h100, 12'h0FF, 1'b0, 0);
    run_access(12'h100, 12'h0FF, 1'b1, 0);
    run_access(12'h0FF, 12'h0FF, 1'b0, 0);
    run_access(12'h000, 12'h0FF, 1'b0, 0);
    run_access(12'h800, 12'h0FF, 1'b0, 0);
    run_access(12'h0FE, 12'h0FF, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_access(PW'($urandom_range(0, 4095)), PW'($urandom_range(0, 4095)),
                 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_req_during_scan();
    run_access(12'h001, 12'h002, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    run_access(12'h555, 12'h300, 1'b0, 2);
  endtask

  task automatic test_freeze();
    run_access(12'hA5A, 12'h123, 1'b0, 3);
  endtask

  task automatic test_reset_mid();
    run_access(12'h100, 12'h0FF, 1'b0, 4);
    run_access(12'h000, 12'h001, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_req_during_scan();
    test_back_to_back();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdl_pgaccess_seq.md
# mdl_pgaccess_seq

Page access sequencer for the 005297 bubble memory controller. It accepts one page access request at a time and loads the 12-bit page number into a serial shift register. It then steps a 20-phase active-low rotation ring on the 2 MHz clock enable, serially compares the page against the invalid-page limit, and reports the valid/invalid result to the access control logic. It is the block that drives the invalid-page detection path.

## Interface
Parameters:
- PG_W, 12, page number width; must be ≤ 20.

Ports:
- i_MCLK  in  1  master clock; all flops on its rising edge.
- i_RST  in  1  reset; asynchronous, active-high.
- i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active-low. All state advances only when it is 0.
- i_REQ  in  1  access request level; sampled in IDLE only.
- i_PAGE  in  PG_W  requested page number; captured on acceptance.
- i_INVALPG  in  PG_W  invalid page limit; captured on acceptance.
- i_UMODE_n  in  1  user mode, active-low; 1 suppresses the invalid result.
- o_ACK  out  1  one-MCLK pulse when the request is accepted.
- o_BUSY  out  1  high from acceptance until the sequence is complete.
- o_ROT20_n  out  20  one-hot active-low step ring; all 1 when not busy.
- o_PGREG_SR_LSB  out  1  current LSB of the page shift register.
- o_ACC_INVAL_n  out  1  0 means the current access is invalid.
- o_DONE  out  1  one-MCLK pulse at the end of step 19.

## Operation
- States:
  - IDLE: ring all 1.
  - LOAD: one enable tick.
  - SCAN: steps 0..19.
  - IDLE: return after step 19.
- IDLE → LOAD: on the first MCLK edge with i_REQ=1.
  - Capture i_PAGE and i_INVALPG into shift registers.
  - Pulse o_ACK.
  - Set o_BUSY.
- LOAD → SCAN: on the next enable tick. The 5-bit step counter is set to 0, and o_ROT20_n[0] goes to 0.
- SCAN: on each enable tick, the step counter increments and the ring rotates (bit k is low during step k).
- Steps 0..PG_W-1: both shift registers shift right by one bit, LSB first, and the compare accumulator updates.
- Steps PG_W..19: no shifting; the registers hold.
- Accumulator (INVALPG_GTE_EN defined):
  - Cleared at LOAD.
  - Update: borrow ← (~p & l) | (~(p ^ l) & borrow).
  - Invalid = ~borrow, i.e. page ≥ limit.
- Latch point: on the tick entering step 12, latch o_ACC_INVAL_n = ~(invalid & ~i_UMODE_n). Hold it until the next LOAD.
- Exit: on the tick that leaves step 19, pulse o_DONE, clear o_BUSY, set the ring to all 1, and go to IDLE.
- i_REQ while not in IDLE: ignored, with no ACK. A request held high through DONE is accepted again in the next IDLE.
- Reset mid-sequence: asynchronous return to IDLE with all outputs at their reset values.

## Timing
- Reset values:
  - o_ROT20_n = 20'hFFFFF.
  - o_ACK = 0, o_BUSY = 0, o_DONE = 0.
  - o_ACC_INVAL_n = 1.
  - o_PGREG_SR_LSB = 0.
  - Step counter = 0, state = IDLE.
- REQ → ACK: 1 MCLK. ACK and BUSY rise on the same edge.
- ACK → step 0: the first enable tick after acceptance (LOAD) plus one further tick.
- Result: valid from the step-12 tick edge.
- Total sequence: 21 enable ticks from LOAD to DONE. The next request can be accepted on the MCLK after DONE.
- Enable held 1: the block freezes in place and holds all outputs.
- Step counter: never exceeds 19. The value 19 wraps to IDLE, not to step 0.

## Configuration
- INVALPG_GTE_EN defined: the invalid test is page ≥ i_INVALPG, using the serial borrow chain.
- INVALPG_GTE_EN undefined:
  - Invalid test is page == 0; the accumulator ORs the shifted page bits.
  - i_INVALPG is ignored and its register is not built.

## Structure
- Shared package pgseq_pkg holds:
  - The state enum (IDLE, LOAD, SCAN).
  - Constants ROT_STEPS = 20 and RESULT_STEP = 12.
  - PG_W default.
- Sub-module mdl_pgserial_cmp: the serial accumulator, with the macro-selected compare inside. Ports are clear, shift-enable, page bit, limit bit, and invalid.
- The top level holds the FSM, step counter, ring, and shift registers.

## Test plan
- Reset mid-SCAN at step 7 → o_ROT20_n = FFFFF, o_BUSY = 0, o_ACC_INVAL_n = 1 immediately, without waiting for a clock.
- i_PAGE = 0x100, i_INVALPG = 0x0FF, i_UMODE_n = 0, GTE build → o_ACC_INVAL_n = 0 from step 12. DONE comes 21 ticks after LOAD.
- Same stimulus with i_UMODE_n = 1 → o_ACC_INVAL_n stays 1. Boundary case page = limit = 0x0FF, UMODE_n = 0 → invalid (0).
- Non-GTE build: i_PAGE = 0x000 → invalid. i_PAGE = 0x800 → valid. o_PGREG_SR_LSB emits the bits 0,0,…,1 over steps 0..11.
- i_REQ pulsed during SCAN → no ACK. i_REQ held high through DONE → second ACK 1 MCLK after DONE.
- i_CLK2M_PCEN_n stuck at 1 for 50 MCLK during step 5 → ring stays at bit 5 low and no outputs change. Scanning resumes once the enable toggles.
